// File: rtl/sup1_pkg.sv
// Shared definitions for the SUP-1 control sequencer: opcodes, T-states and ctrl bit layout.
// Conditional jumps (JC/JZ) are enabled by defining CONDJMP_EN.
package sup1_pkg;

  localparam int OP_W      = 4;
  localparam int T_W       = 3;
  localparam int MAX_STEPS = 5;
  localparam int CTRL_W    = 15;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [T_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  // ctrl = {mi,ro,ri,io,ii,ai,ao,bi,eo,su,fi,oi,ce,co,j}
  localparam int B_MI = 14;
  localparam int B_RO = 13;
  localparam int B_RI = 12;
  localparam int B_IO = 11;
  localparam int B_II = 10;
  localparam int B_AI = 9;
  localparam int B_AO = 8;
  localparam int B_BI = 7;
  localparam int B_EO = 6;
  localparam int B_SU = 5;
  localparam int B_FI = 4;
  localparam int B_OI = 3;
  localparam int B_CE = 2;
  localparam int B_CO = 1;
  localparam int B_J  = 0;

  localparam logic [CTRL_W-1:0] C_MI = CTRL_W'(1) << B_MI;
  localparam logic [CTRL_W-1:0] C_RO = CTRL_W'(1) << B_RO;
  localparam logic [CTRL_W-1:0] C_RI = CTRL_W'(1) << B_RI;
  localparam logic [CTRL_W-1:0] C_IO = CTRL_W'(1) << B_IO;
  localparam logic [CTRL_W-1:0] C_II = CTRL_W'(1) << B_II;
  localparam logic [CTRL_W-1:0] C_AI = CTRL_W'(1) << B_AI;
  localparam logic [CTRL_W-1:0] C_AO = CTRL_W'(1) << B_AO;
  localparam logic [CTRL_W-1:0] C_BI = CTRL_W'(1) << B_BI;
  localparam logic [CTRL_W-1:0] C_EO = CTRL_W'(1) << B_EO;
  localparam logic [CTRL_W-1:0] C_SU = CTRL_W'(1) << B_SU;
  localparam logic [CTRL_W-1:0] C_FI = CTRL_W'(1) << B_FI;
  localparam logic [CTRL_W-1:0] C_OI = CTRL_W'(1) << B_OI;
  localparam logic [CTRL_W-1:0] C_CE = CTRL_W'(1) << B_CE;
  localparam logic [CTRL_W-1:0] C_CO = CTRL_W'(1) << B_CO;
  localparam logic [CTRL_W-1:0] C_J  = CTRL_W'(1) << B_J;

endpackage

// File: rtl/control_decode.sv
// Combinational microcode: (tstate, opcode, flags) -> ctrl strobes and end-of-instruction flag.
// JC/JZ decode only when CONDJMP_EN is defined; otherwise they fall through as NOP.
module control_decode
  import sup1_pkg::*;
(
  input  tstate_e           tstate,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last_step
);

  logic has_exec;

  always_comb begin
    has_exec = 1'b1;
    case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_OUT, OP_HLT: has_exec = 1'b1;
`ifdef CONDJMP_EN
      OP_JC, OP_JZ: has_exec = 1'b1;
`endif
      default: has_exec = 1'b0;
    endcase
  end

`ifndef CONDJMP_EN
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
`endif

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    case (tstate)
      T0: ctrl = C_CO | C_MI;
      T1: begin
        ctrl      = C_RO | C_II | C_CE;
        last_step = ~has_exec;
      end
      default: begin
        // Unreachable opcode/step pairs end the instruction so the counter recovers.
        last_step = 1'b1;
        case (opcode)
          OP_LDA: begin
            if (tstate == T2) begin ctrl = C_IO | C_MI; last_step = 1'b0; end
            else if (tstate == T3) ctrl = C_RO | C_AI;
          end
          OP_ADD, OP_SUB: begin
            if (tstate == T2) begin ctrl = C_IO | C_MI; last_step = 1'b0; end
            else if (tstate == T3) begin ctrl = C_RO | C_BI; last_step = 1'b0; end
            else if (tstate == T4) ctrl = C_EO | C_AI | C_FI | ((opcode == OP_SUB) ? C_SU : '0);
          end
          OP_STA: begin
            if (tstate == T2) begin ctrl = C_IO | C_MI; last_step = 1'b0; end
            else if (tstate == T3) ctrl = C_AO | C_RI;
          end
          OP_LDI: if (tstate == T2) ctrl = C_IO | C_AI;
          OP_JMP: if (tstate == T2) ctrl = C_IO | C_J;
          OP_OUT: if (tstate == T2) ctrl = C_AO | C_OI;
`ifdef CONDJMP_EN
          OP_JC:  if (tstate == T2 && flag_c) ctrl = C_IO | C_J;
          OP_JZ:  if (tstate == T2 && flag_z) ctrl = C_IO | C_J;
`endif
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SUP-1 microstep sequencer: T-state counter and halt latch around the control_decode microcode.
// Build with CONDJMP_EN defined to enable JC/JZ.
//
// state | meaning
// T0    | fetch: PC -> MAR
// T1    | fetch: RAM -> IR, PC++ (NOP ends here)
// T2    | execute step 1 (LDI/JMP/OUT/HLT/JC/JZ end here)
// T3    | execute step 2 (LDA/STA end here)
// T4    | execute step 3 (ADD/SUB)
module control_sequencer
  import sup1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        instr,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic [T_W-1:0]    tstate,
  output logic              halted
);

  tstate_e           state_q, state_d;
  logic              halted_q, halted_d;
  logic [OP_W-1:0]   opcode;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              last_step;
  logic              unused_operand;

  assign opcode         = instr[7:4];
  assign unused_operand = ^instr[3:0];

  control_decode u_decode (
    .tstate    (state_q),
    .opcode    (opcode),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .ctrl      (dec_ctrl),
    .last_step (last_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (last_step || (state_q >= tstate_e'(T_W'(MAX_STEPS - 1))))
        state_d = T0;
      else
        state_d = tstate_e'(state_q + T_W'(1));
      if (state_q == T2 && opcode == OP_HLT)
        halted_d = 1'b1;
    end
  end

  // Strobes are gated by the raw reset so nothing leaks out while rst is held.
  assign ctrl   = (rst || halted_q) ? '0 : dec_ctrl;
  assign tstate = state_q;
  assign halted = halted_q;

  bus_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ctrl[B_RO], ctrl[B_IO], ctrl[B_AO], ctrl[B_EO], ctrl[B_CO]}));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed plus random instruction streams vs. a table model.
// Define CONDJMP_EN for both bench and RTL to cover JC/JZ.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr;
  logic        flag_c;
  logic        flag_z;
  logic [14:0] ctrl;
  logic [2:0]  tstate;
  logic        halted;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] MI = 15'h4000, RO = 15'h2000, RI = 15'h1000, IO = 15'h0800;
  localparam logic [14:0] II = 15'h0400, AI = 15'h0200, AO = 15'h0100, BI = 15'h0080;
  localparam logic [14:0] EO = 15'h0040, SU = 15'h0020, FI = 15'h0010, OI = 15'h0008;
  localparam logic [14:0] CE = 15'h0004, CO = 15'h0002, JJ = 15'h0001;

  logic [14:0] exp_seq [0:4];
  int          exp_len;

  control_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .tstate (tstate),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_ok(input logic [14:0] c);
    int n;
    n = int'(c[13]) + int'(c[11]) + int'(c[8]) + int'(c[6]) + int'(c[1]);
    return n <= 1;
  endfunction

  // Expected strobe list for one whole instruction, fetch included.
  task automatic build_steps(input logic [3:0] op, input logic fc, input logic fz);
    exp_seq[0] = CO | MI;
    exp_seq[1] = RO | II | CE;
    exp_len    = 2;
    case (op)
      4'h1: begin exp_seq[2] = IO | MI; exp_seq[3] = RO | AI; exp_len = 4; end
      4'h2, 4'h3: begin
        exp_seq[2] = IO | MI;
        exp_seq[3] = RO | BI;
        exp_seq[4] = EO | AI | FI | ((op == 4'h3) ? SU : 15'h0);
        exp_len    = 5;
      end
      4'h4: begin exp_seq[2] = IO | MI; exp_seq[3] = AO | RI; exp_len = 4; end
      4'h5: begin exp_seq[2] = IO | AI; exp_len = 3; end
      4'h6: begin exp_seq[2] = IO | JJ; exp_len = 3; end
      4'hE: begin exp_seq[2] = AO | OI; exp_len = 3; end
      4'hF: begin exp_seq[2] = 15'h0;   exp_len = 3; end
`ifdef CONDJMP_EN
      4'h7: begin exp_seq[2] = fc ? (IO | JJ) : 15'h0; exp_len = 3; end
      4'h8: begin exp_seq[2] = fz ? (IO | JJ) : 15'h0; exp_len = 3; end
`endif
      default: ;
    endcase
  endtask

  // Call with the sequencer sitting in T0, away from a clock edge.
  task automatic run_instr(input logic [7:0] ins, input logic fc, input logic fz, input string tag);
    build_steps(ins[7:4], fc, fz);
    instr  = ins;
    flag_c = fc;
    flag_z = fz;
    #1;
    for (int i = 0; i < exp_len; i++) begin
      check_val({tag, " tstate"}, 32'(tstate), 32'(i));
      check_val({tag, " ctrl"}, 32'(ctrl), 32'(exp_seq[i]));
      check_val({tag, " halted"}, 32'(halted), 32'd0);
      check_val({tag, " bus"}, 32'(bus_ok(ctrl)), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    instr  = 8'h00;
    flag_c = 1'b0;
    flag_z = 1'b0;
    #1;
    check_val("rst tstate", 32'(tstate), 32'd0);
    check_val("rst ctrl", 32'(ctrl), 32'd0);
    check_val("rst halted", 32'(halted), 32'd0);
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post rst ctrl", 32'(ctrl), 32'(CO | MI));

    // Abort an LDA in T3 with an asynchronous reset.
    instr = 8'h1A;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_val("lda t3 tstate", 32'(tstate), 32'd3);
    check_val("lda t3 ctrl", 32'(ctrl), 32'(RO | AI));
    rst = 1'b1;
    #1;
    check_val("abort tstate", 32'(tstate), 32'd0);
    check_val("abort ctrl", 32'(ctrl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort t0 ctrl", 32'(ctrl), 32'(CO | MI));

    run_instr(8'h1A, 1'b0, 1'b0, "lda");
    run_instr(8'h23, 1'b1, 1'b0, "add");
    run_instr(8'h37, 1'b0, 1'b1, "sub");
    run_instr(8'h4F, 1'b0, 1'b0, "sta");
    run_instr(8'h55, 1'b0, 1'b0, "ldi");
    run_instr(8'h63, 1'b0, 1'b0, "jmp");
    run_instr(8'hE0, 1'b0, 1'b0, "out");
    run_instr(8'h00, 1'b0, 1'b0, "nop");
    run_instr(8'h85, 1'b0, 1'b1, "jz taken");
    run_instr(8'h85, 1'b1, 1'b0, "jz not taken");
    run_instr(8'h72, 1'b1, 1'b0, "jc taken");
    run_instr(8'h72, 1'b0, 1'b1, "jc not taken");
    run_instr(8'hA9, 1'b1, 1'b1, "unassigned");

    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom)}, 1'($urandom), 1'($urandom), "rand");
    end
    check_val("end of stream tstate", 32'(tstate), 32'd0);

    run_instr(8'hF0, 1'b0, 1'b0, "hlt");
    check_val("hlt halted", 32'(halted), 32'd1);
    for (int n = 0; n < 10; n++) begin
      instr  = 8'($urandom);
      flag_c = 1'($urandom);
      flag_z = 1'($urandom);
      @(posedge clk);
      #1;
      check_val("frozen tstate", 32'(tstate), 32'd0);
      check_val("frozen ctrl", 32'(ctrl), 32'd0);
      check_val("frozen halted", 32'(halted), 32'd1);
    end
    rst = 1'b1;
    #1;
    check_val("unhalt halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(8'h5C, 1'b0, 1'b0, "ldi after halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
